// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch front end.
//   - seq_state_e    : pc_sequencer FSM state encoding
//   - BR_*           : control-flow select codes presented on br_s
//   - is_taken_code  : decodes a br_s value into "redirect taken"
package cpu_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } seq_state_e;

    // JAL and JALR ignore br_s[0]; BRANCH is an exact 4-bit match.
    localparam logic [2:0] BR_JAL_HI  = 3'b111;
    localparam logic [2:0] BR_JALR_HI = 3'b101;
    localparam logic [3:0] BR_BRANCH  = 4'b1001;

    function automatic logic is_taken_code(input logic [3:0] s);
        return (s[3:1] == BR_JAL_HI) || (s[3:1] == BR_JALR_HI) || (s == BR_BRANCH);
    endfunction

endpackage

// File: rtl/next_pc_unit.sv
// next_pc_unit: combinational redirect-target and taken decode.
// Ports:
//   br_valid  in   execute presents a resolved control-flow instruction
//   br_s      in   4-bit select code
//   br_imm    in   signed immediate (halfword offset, shifted left by one)
//   br_alu    in   ALU result used as indirect target
//   br_pc     in   PC of the control-flow instruction
//   taken     out  redirect must be applied this cycle
//   target    out  redirect address, modulo 2^PC_WIDTH
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  br_valid,
    input  logic [3:0]            br_s,
    input  logic [DATA_WIDTH-1:0] br_imm,
    input  logic [DATA_WIDTH-1:0] br_alu,
    input  logic [PC_WIDTH-1:0]   br_pc,
    output logic                  taken,
    output logic [PC_WIDTH-1:0]   target
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic [DATA_WIDTH-1:0] imm_shl;
    logic [PC_WIDTH-1:0]   imm_off;
    logic                  unused_bits;

    assign imm_shl = br_imm << 1;
    // Only the low PC_WIDTH bits matter because all target math wraps.
    assign imm_off = imm_shl[PC_WIDTH-1:0];
    assign unused_bits = ^{imm_shl, br_alu};

    always_comb begin
        target = br_pc + PC_STEP;
        if (br_s[3:1] == BR_JAL_HI) begin
            target = br_pc + imm_off;
        end else if (br_s[3:1] == BR_JALR_HI) begin
            target = br_alu[PC_WIDTH-1:0];
        end else if (br_s == BR_BRANCH) begin
            target = br_pc + imm_off;
        end
    end

    assign taken = br_valid && is_taken_code(br_s);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch FSM, program counter and single-entry instruction buffer.
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   imem_req/addr/ack/rdata instruction memory fetch (ack returns data same cycle)
//   instr_valid/instr/instr_pc/instr_ready  buffered instruction to decode
//   br_valid/s/imm/alu/pc   resolved control flow from execute
//   pc                      current fetch PC
//   flush                   one-cycle pulse after a taken redirect
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned          PC_WIDTH   = 8,
    parameter int unsigned          DATA_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   instr_pc,
    input  logic                  instr_ready,
    input  logic                  br_valid,
    input  logic [3:0]            br_s,
    input  logic [DATA_WIDTH-1:0] br_imm,
    input  logic [DATA_WIDTH-1:0] br_alu,
    input  logic [PC_WIDTH-1:0]   br_pc,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  flush
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    seq_state_e            state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  flush_q, flush_d;

    logic                  taken;
    logic [PC_WIDTH-1:0]   target;

    next_pc_unit #(
        .PC_WIDTH   (PC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc_unit (
        .br_valid (br_valid),
        .br_s     (br_s),
        .br_imm   (br_imm),
        .br_alu   (br_alu),
        .br_pc    (br_pc),
        .taken    (taken),
        .target   (target)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        flush_d       = taken;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    pc_d          = pc_q + PC_STEP;
                    instr_valid_d = 1'b1;
                    state_d       = StHold;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = StFetch;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A redirect beats any same-cycle fetch return or decode handshake:
        // the fetched word is thrown away and the buffer is emptied.
        if (taken) begin
            pc_d          = target;
            instr_d       = instr_q;
            instr_pc_d    = instr_pc_q;
            instr_valid_d = 1'b0;
            state_d       = StFetch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            flush_q       <= flush_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc          = pc_q;
    assign flush       = flush_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of every program-counter value.
REQ-002 Parameter DATA_WIDTH, default 32, width of instruction, immediate and ALU-result buses.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 imem_req  output  1  fetch request to instruction memory.
REQ-007 imem_addr  output  PC_WIDTH  fetch address; equals pc while imem_req=1.
REQ-008 imem_ack  input  1  imem_rdata valid for imem_addr in this same cycle.
REQ-009 imem_rdata  input  DATA_WIDTH  fetched instruction word.
REQ-010 instr_valid  output  1  buffered instruction available to decode.
REQ-011 instr  output  DATA_WIDTH  buffered instruction.
REQ-012 instr_pc  output  PC_WIDTH  address the buffered instruction was fetched from.
REQ-013 instr_ready  input  1  decode accepts instr this cycle when instr_valid=1.
REQ-014 br_valid  input  1  execute presents a resolved control-flow instruction.
REQ-015 br_s  input  4  control-flow select code.
REQ-016 br_imm  input  DATA_WIDTH  signed immediate.
REQ-017 br_alu  input  DATA_WIDTH  ALU result (indirect target).
REQ-018 br_pc  input  PC_WIDTH  PC of the control-flow instruction.
REQ-019 pc  output  PC_WIDTH  current fetch PC register.
REQ-020 flush  output  1  one-cycle pulse: redirect taken, younger work discarded.

Function
REQ-021 Target: br_s=111? -> br_pc+(br_imm<<1); 101? -> br_alu[PC_WIDTH-1:0]; 1001 -> br_pc+(br_imm<<1); else -> br_pc+4; all arithmetic truncated modulo 2^PC_WIDTH.
REQ-022 taken = br_valid and br_s in {111?, 101?, 1001}; br_valid with any other code has no effect.
REQ-023 FSM states IDLE, FETCH, HOLD; IDLE -> FETCH unconditionally after one cycle.
REQ-024 FETCH: imem_req=1; on imem_ack, capture imem_rdata into instr, pc into instr_pc, pc <= pc+4 (wrapping), go HOLD.
REQ-025 HOLD: imem_req=0, instr_valid=1; on instr_ready, instr_valid clears next cycle, go FETCH; instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-026 taken in any state: pc <= target, flush=1 next cycle for exactly one cycle, buffered instruction dropped (instr_valid=0 next cycle), state <= FETCH.
REQ-027 taken with imem_ack in the same FETCH cycle: fetched word discarded, pc <= target (not pc+4).
REQ-028 taken with instr_ready in the same HOLD cycle: redirect wins; handshake still counts as accepted, no duplicate delivery.
REQ-029 taken in IDLE: pc <= target, FETCH next cycle.
REQ-030 Fetch latency: first imem_req two cycles after reset deasserts; max throughput one instruction per two cycles.
REQ-031 pc wraps from 2^PC_WIDTH-4 to 0 with no error indication.

Reset
REQ-032 reset=1 at a clock edge: state <= IDLE, pc <= RESET_PC, instr_valid/flush/imem_req <= 0, instr <= 0, instr_pc <= 0.
REQ-033 Reset asserted mid-fetch or mid-hold overrides all other inputs including taken redirects; no output beyond those in REQ-032 depends on pre-reset state.

Structure
REQ-034 FSM state encoding and br_s select-code constants (JAL 111?, JALR 101?, BRANCH 1001) in shared package cpu_pkg.
REQ-035 Target computation (REQ-021) in combinational sub-module next_pc_unit; FSM, PC and instruction buffer in pc_sequencer.

Verification
REQ-036 Reset release, imem_ack=1 always, instr_ready=1 -> imem_addr 0x00, 0x04, 0x08 on successive FETCH cycles, instr_pc matches.
REQ-037 HOLD with instr_ready=0 for 5 cycles -> instr/instr_pc unchanged, imem_req=0 throughout.
REQ-038 br_valid=1, br_s=1110, br_pc=0x10, br_imm=-4 -> pc=0x08 next cycle, flush=1 for one cycle, instr_valid=0.
REQ-039 br_s=1010, br_alu=0x1234 in FETCH with imem_ack=1 -> pc=0x34, fetched word discarded.
REQ-040 pc=0xFC, ack -> pc=0x00; br_s=0110 with br_valid=1 -> no flush, pc unchanged.
REQ-041 reset asserted in HOLD with simultaneous taken redirect -> pc=RESET_PC, all outputs 0 next cycle.
